// File: rtl/user_mgr_arb.sv
// Round-robin OBI manager arbiter with in-order response routing via an ID FIFO.
// Define USER_MGR_ARB_STATS_EN to add per-requester saturating grant counters.
module user_mgr_arb #(
  parameter int NumReq    = 2,
  parameter int MaxTrans  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  output logic [NumReq-1:0]                     gnt_o,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [NumReq-1:0]                     err_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  mgr_req_o,
  output logic [AddrWidth-1:0]                  mgr_addr_o,
  output logic                                  mgr_we_o,
  output logic [DataWidth/8-1:0]                mgr_be_o,
  output logic [DataWidth-1:0]                  mgr_wdata_o,
  input  logic                                  mgr_gnt_i,
  input  logic                                  mgr_rvalid_i,
  input  logic                                  mgr_err_i,
  input  logic [DataWidth-1:0]                  mgr_rdata_i,
  output logic                                  busy_o
`ifdef USER_MGR_ARB_STATS_EN
  ,
  output logic [NumReq-1:0][15:0]               grant_cnt_o
`endif
);

  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW = $clog2(MaxTrans + 1);

  typedef enum logic {StFree, StLock} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, lock_idx_q;
  logic [IdxW-1:0] rr_idx, sel, head;
  logic            rr_found, sel_valid;
  logic            full, push, pop;
  logic [IdxW-1:0] ids_q [MaxTrans];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;

  function automatic logic [IdxW-1:0] wrap_add(
    input logic [IdxW-1:0] p,
    input int              i
  );
    int s;
    s = (int'(p) + i) % NumReq;
    return IdxW'(s);
  endfunction

  function automatic logic [PtrW-1:0] fifo_nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int i = 1; i <= NumReq; i++) begin
      if (!rr_found && req_i[wrap_add(ptr_q, i)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  // A stalled handshake pins the selection until the downstream grants it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StFree;
      lock_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFree && state_d == StLock) lock_idx_q <= sel;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFree:  if (mgr_req_o && !mgr_gnt_i) state_d = StLock;
      StLock:  if (!mgr_req_o || mgr_gnt_i) state_d = StFree;
      default: state_d = StFree;
    endcase
  end

  always_comb begin
    sel       = rr_idx;
    sel_valid = rr_found;
    if (state_q == StLock) begin
      sel       = lock_idx_q;
      sel_valid = req_i[lock_idx_q];
    end
    mgr_req_o   = sel_valid && !full && !rst_i;
    mgr_addr_o  = addr_i[sel];
    mgr_we_o    = we_i[sel];
    mgr_be_o    = be_i[sel];
    mgr_wdata_o = wdata_i[sel];
    gnt_o       = '0;
    if (mgr_req_o && mgr_gnt_i) gnt_o[sel] = 1'b1;
  end

  assign full = (cnt_q == CntW'(MaxTrans));
  assign push = mgr_req_o && mgr_gnt_i;
  assign pop  = mgr_rvalid_i && (cnt_q != '0) && !rst_i;
  assign head = ids_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= IdxW'(NumReq - 1);
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        ptr_q <= sel;
        wr_q  <= fifo_nxt(wr_q);
      end
      if (pop) rd_q <= fifo_nxt(rd_q);
      if (push && !pop) cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) ids_q[wr_q] <= sel;
  end

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    if (pop) begin
      rvalid_o[head] = 1'b1;
      err_o[head]    = mgr_err_i;
    end
  end

  assign rdata_o = mgr_rdata_i;
  assign busy_o  = (cnt_q != '0) && !rst_i;

`ifdef USER_MGR_ARB_STATS_EN
  logic [NumReq-1:0][15:0] grant_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        if (gnt_o[k] && grant_cnt_q[k] != 16'hFFFF)
          grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`else
  // Default build carries no grant counters.
`endif

endmodule

// File: tb/tb_user_mgr_arb.sv
// Bench for user_mgr_arb: directed vector table, hand sequences, and a
// randomized run against a queue-based reference model.
module tb_user_mgr_arb;

  localparam int N  = 2;
  localparam int MT = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [N-1:0]             req;
  logic [N-1:0][AW-1:0]     addr;
  logic [N-1:0]             we;
  logic [N-1:0][DW/8-1:0]   be;
  logic [N-1:0][DW-1:0]     wdata;
  logic [N-1:0]             gnt_o, rvalid_o, err_o;
  logic [DW-1:0]            rdata_o;
  logic                     mgr_req;
  logic [AW-1:0]            mgr_addr;
  logic                     mgr_we;
  logic [DW/8-1:0]          mgr_be;
  logic [DW-1:0]            mgr_wdata;
  logic                     mgr_gnt, mgr_rv, mgr_err;
  logic [DW-1:0]            mgr_rdata;
  logic                     busy;
`ifdef USER_MGR_ARB_STATS_EN
  logic [N-1:0][15:0]       grant_cnt;
`endif

  user_mgr_arb #(
    .NumReq(N), .MaxTrans(MT), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .addr_i(addr),
    .we_i(we),
    .be_i(be),
    .wdata_i(wdata),
    .gnt_o(gnt_o),
    .rvalid_o(rvalid_o),
    .err_o(err_o),
    .rdata_o(rdata_o),
    .mgr_req_o(mgr_req),
    .mgr_addr_o(mgr_addr),
    .mgr_we_o(mgr_we),
    .mgr_be_o(mgr_be),
    .mgr_wdata_o(mgr_wdata),
    .mgr_gnt_i(mgr_gnt),
    .mgr_rvalid_i(mgr_rv),
    .mgr_err_i(mgr_err),
    .mgr_rdata_i(mgr_rdata),
    .busy_o(busy)
`ifdef USER_MGR_ARB_STATS_EN
    ,
    .grant_cnt_o(grant_cnt)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic       er;
    logic [1:0] e_gnt;
    logic       e_req;
    logic [1:0] e_rv;
    logic [1:0] e_err;
    logic       e_busy;
  } vec_t;

  vec_t tbl [14];

  int            m_ptr, m_lidx, e_sel, j;
  bit            m_lock, e_req, e_pop, e_busy;
  int            m_q [$];
  logic [N-1:0]  e_gnt, e_rv, e_err;

  initial begin
    rst = 1'b1; req = '0; we = '0; be = '0; wdata = '0;
    mgr_gnt = 1'b0; mgr_rv = 1'b0; mgr_err = 1'b0; mgr_rdata = '0;
    addr[0] = 32'h1000_0000;
    addr[1] = 32'h2000_0000;

    //          rst req    gnt rv er  egnt  ereq erv    eerr   ebusy
    tbl[0]  = '{1, 2'b11, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0};
    tbl[1]  = '{0, 2'b11, 1, 0, 0, 2'b01, 1, 2'b00, 2'b00, 0};
    tbl[2]  = '{0, 2'b11, 1, 1, 0, 2'b10, 1, 2'b01, 2'b00, 1};
    tbl[3]  = '{0, 2'b11, 1, 1, 0, 2'b01, 1, 2'b10, 2'b00, 1};
    tbl[4]  = '{0, 2'b11, 1, 1, 0, 2'b10, 1, 2'b01, 2'b00, 1};
    tbl[5]  = '{0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b10, 2'b00, 1};
    tbl[6]  = '{0, 2'b00, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0};
    tbl[7]  = '{0, 2'b11, 1, 0, 0, 2'b01, 1, 2'b00, 2'b00, 0};
    tbl[8]  = '{0, 2'b11, 1, 0, 0, 2'b10, 1, 2'b00, 2'b00, 1};
    tbl[9]  = '{0, 2'b11, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1};
    tbl[10] = '{0, 2'b11, 1, 1, 0, 2'b00, 0, 2'b01, 2'b00, 1};
    tbl[11] = '{0, 2'b11, 1, 0, 0, 2'b01, 1, 2'b00, 2'b00, 1};
    tbl[12] = '{1, 2'b11, 1, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0};
    tbl[13] = '{0, 2'b00, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; mgr_gnt = tbl[i].gnt;
      mgr_rv = tbl[i].rv; mgr_err = tbl[i].er;
      #1;
      chk($sformatf("vec%0d gnt", i), gnt_o, tbl[i].e_gnt);
      chk($sformatf("vec%0d mgr_req", i), mgr_req, tbl[i].e_req);
      chk($sformatf("vec%0d rvalid", i), rvalid_o, tbl[i].e_rv);
      chk($sformatf("vec%0d err", i), err_o, tbl[i].e_err);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
    end

    // Stalled handshake keeps requester 0 selected.
    @(negedge clk);
    rst = 1'b1; req = '0; mgr_gnt = 1'b0; mgr_rv = 1'b0; mgr_err = 1'b0;
    @(negedge clk);
    rst = 1'b0; req = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lock%0d addr", c), mgr_addr, 32'h1000_0000);
      chk($sformatf("lock%0d gnt", c), gnt_o, 2'b00);
      @(negedge clk);
    end
    mgr_gnt = 1'b1;
    #1;
    chk("lock release gnt", gnt_o, 2'b01);

    // Responses route back in issue order.
    @(negedge clk);
    rst = 1'b1; req = '0; mgr_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0; req = 2'b10; mgr_gnt = 1'b1;
    #1; chk("order gnt1", gnt_o, 2'b10);
    @(negedge clk);
    req = 2'b01;
    #1; chk("order gnt0", gnt_o, 2'b01);
    @(negedge clk);
    req = '0; mgr_gnt = 1'b0; mgr_rv = 1'b1;
    mgr_rdata = 32'hA5A5_A5A5; mgr_err = 1'b0;
    #1;
    chk("resp1 rvalid", rvalid_o, 2'b10);
    chk("resp1 rdata", rdata_o, 32'hA5A5_A5A5);
    chk("resp1 err", err_o, 2'b00);
    @(negedge clk);
    mgr_rdata = 32'h5A5A_5A5A; mgr_err = 1'b1;
    #1;
    chk("resp2 rvalid", rvalid_o, 2'b01);
    chk("resp2 rdata", rdata_o, 32'h5A5A_5A5A);
    chk("resp2 err", err_o, 2'b01);
    @(negedge clk);
    mgr_rv = 1'b0; mgr_err = 1'b0;

    // Randomized run against the reference model.
    m_ptr = N - 1; m_lock = 0; m_lidx = 0; m_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst       = (c == 0) || ($urandom_range(0, 49) == 0);
      req       = N'($urandom_range(0, 3));
      mgr_gnt   = ($urandom_range(0, 2) != 0);
      mgr_rv    = 1'($urandom_range(0, 1));
      mgr_err   = 1'($urandom_range(0, 1));
      mgr_rdata = $urandom;
      for (int k = 0; k < N; k++) begin
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        we[k]    = 1'($urandom_range(0, 1));
        be[k]    = 4'($urandom_range(0, 15));
      end
      #1;
      e_sel = -1;
      if (m_lock) begin
        if (req[m_lidx]) e_sel = m_lidx;
      end else begin
        for (int i = 1; i <= N; i++) begin
          j = (m_ptr + i) % N;
          if (e_sel < 0 && req[j]) e_sel = j;
        end
      end
      e_req = !rst && (e_sel >= 0) && (m_q.size() < MT);
      e_gnt = '0;
      if (e_req && mgr_gnt) e_gnt[e_sel] = 1'b1;
      e_pop = !rst && mgr_rv && (m_q.size() > 0);
      e_rv = '0; e_err = '0;
      if (e_pop) begin
        e_rv[m_q[0]]  = 1'b1;
        e_err[m_q[0]] = mgr_err;
      end
      e_busy = !rst && (m_q.size() > 0);
      chk($sformatf("rnd%0d gnt", c), gnt_o, e_gnt);
      chk($sformatf("rnd%0d mgr_req", c), mgr_req, e_req);
      chk($sformatf("rnd%0d rvalid", c), rvalid_o, e_rv);
      chk($sformatf("rnd%0d err", c), err_o, e_err);
      chk($sformatf("rnd%0d busy", c), busy, e_busy);
      chk($sformatf("rnd%0d rdata", c), rdata_o, mgr_rdata);
      if (e_req) begin
        chk($sformatf("rnd%0d addr", c), mgr_addr, addr[e_sel]);
        chk($sformatf("rnd%0d wdata", c), mgr_wdata, wdata[e_sel]);
        chk($sformatf("rnd%0d we", c), mgr_we, we[e_sel]);
        chk($sformatf("rnd%0d be", c), mgr_be, be[e_sel]);
      end
      if (rst) begin
        m_ptr = N - 1; m_lock = 0; m_q.delete();
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (e_req && mgr_gnt) begin
          m_q.push_back(e_sel);
          m_ptr  = e_sel;
          m_lock = 0;
        end else if (e_req) begin
          m_lock = 1;
          m_lidx = e_sel;
        end else begin
          m_lock = 0;
        end
      end
    end

`ifdef USER_MGR_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b1; req = '0; mgr_gnt = 1'b0; mgr_rv = 1'b0; mgr_err = 1'b0;
    @(negedge clk);
    rst = 1'b0; req = 2'b01; mgr_gnt = 1'b1; mgr_rv = 1'b1;
    for (int c = 0; c < 70000; c++) @(negedge clk);
    req = '0; mgr_gnt = 1'b0; mgr_rv = 1'b0;
    #1;
    chk("stats cnt0", grant_cnt[0], 16'hFFFF);
    chk("stats cnt1", grant_cnt[1], 16'h0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/user_mgr_arb.md
USER_MGR_ARB -- requirements
Module: user_mgr_arb

Interface
REQ-001 The block SHALL have parameter NumReq, default 2, number of requesting user managers (2..8).
REQ-002 The block SHALL have parameter MaxTrans, default 2, maximum outstanding downstream transactions (1..4).
REQ-003 The block SHALL have parameter AddrWidth, default 32, address width.
REQ-004 The block SHALL have parameter DataWidth, default 32, data width.
REQ-005 The block SHALL have one clock, clk_i; reset is synchronous and active-high, on port rst_i.
REQ-006 The block SHALL have port clk_i, input, 1, clock.
REQ-007 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port req_i, input, NumReq, per-requester request.
REQ-009 The block SHALL have port addr_i / we_i / be_i / wdata_i, input, NumReq x (AddrWidth / 1 / DataWidth/8 / DataWidth), per-requester request payload.
REQ-010 The block SHALL have port gnt_o, output, NumReq, per-requester grant.
REQ-011 The block SHALL have port rvalid_o / err_o, output, NumReq / NumReq, per-requester response valid and error.
REQ-012 The block SHALL have port rdata_o, output, DataWidth, response data broadcast to all requesters.
REQ-013 The block SHALL have port mgr_req_o / mgr_addr_o / mgr_we_o / mgr_be_o / mgr_wdata_o, output, 1 / AddrWidth / 1 / DataWidth/8 / DataWidth, downstream OBI request.
REQ-014 The block SHALL have port mgr_gnt_i / mgr_rvalid_i / mgr_err_i / mgr_rdata_i, input, 1 / 1 / 1 / DataWidth, downstream OBI grant and response.
REQ-015 The block SHALL have port busy_o, output, 1, high while any transaction is outstanding.

Function
REQ-016 The block SHALL arbitrate round-robin: among the asserted req_i bits, select the first index strictly after the last-granted pointer, wrapping modulo NumReq.
REQ-017 The block SHALL drive mgr_req_o and the mgr_* payload combinationally from the selected requester, with zero-cycle request latency.
REQ-018 The block SHALL assert gnt_o[k] only in the cycle where k is selected, mgr_req_o=1 and mgr_gnt_i=1.
REQ-019 The block SHALL lock the selection while mgr_req_o=1 and mgr_gnt_i=0, so no other requester can win until the locked handshake completes.
REQ-020 The block SHALL update the pointer to the granted index on each handshake.
REQ-021 The block SHALL push the granted index into an ID FIFO of depth MaxTrans on each handshake.
REQ-022 The block SHALL force mgr_req_o=0 and all gnt_o=0 when the FIFO holds MaxTrans entries; a same-cycle pop does not permit a push (no bypass).
REQ-023 The block SHALL, on mgr_rvalid_i=1, assert rvalid_o[head] and err_o[head]=mgr_err_i in the same cycle, pass mgr_rdata_i to rdata_o, and pop the FIFO.
REQ-024 The block SHALL ignore mgr_rvalid_i while the FIFO is empty: no rvalid_o and no state change.
REQ-025 The block SHALL allow a push and a pop in the same cycle (FIFO count unchanged) when the FIFO is not full.
REQ-026 The block SHALL drive busy_o=1 while the FIFO count is nonzero.
REQ-027 The block SHALL drive rdata_o=mgr_rdata_i at all times; err_o and rvalid_o are 0 when mgr_rvalid_i=0.

Reset
REQ-028 The block SHALL, on rst_i=1 at a clk_i edge, set pointer=NumReq-1 (so index 0 wins first), empty the FIFO, clear the lock, and clear counters.
REQ-029 The block SHALL hold gnt_o=0, mgr_req_o=0, rvalid_o=0, err_o=0 and busy_o=0 while rst_i=1.
REQ-030 The block SHALL discard in-flight transactions on a mid-operation reset, and ignore responses arriving after reset per REQ-024.

Configuration
REQ-031 The block SHALL, when USER_MGR_ARB_STATS_EN is defined, add output grant_cnt_o (NumReq x 16) holding per-requester handshake counts; each count saturates at 16'hFFFF and clears on reset.
REQ-032 The block SHALL, when USER_MGR_ARB_STATS_EN is undefined, omit grant_cnt_o and its counters entirely, leaving all other behaviour identical.

Verification
REQ-033 The bench SHALL check: after reset, req_i=2'b11 and mgr_gnt_i=1 held constant -> grants alternate 0,1,0,1 on consecutive handshake cycles.
REQ-034 The bench SHALL check: req_i=2'b11 with mgr_gnt_i=0 for 3 cycles -> mgr_addr_o stays at requester 0's address and gnt_o stays 0, then gnt_o=2'b01 when mgr_gnt_i=1.
REQ-035 The bench SHALL check: MaxTrans=2, two handshakes with no rvalid -> mgr_req_o=0 in the third cycle, and after one mgr_rvalid_i=1 the next request is issued a cycle later.
REQ-036 The bench SHALL check: handshakes by requesters 1 then 0, then responses with rdata 32'hA5A5A5A5 and 32'h5A5A5A5A with err=1 on the second -> rvalid_o[1] with A5A5A5A5, then rvalid_o[0] with err_o[0]=1.
REQ-037 The bench SHALL check: rst_i pulse with 2 outstanding, then mgr_rvalid_i=1 -> no rvalid_o, busy_o=0.
REQ-038 The bench SHALL check, with USER_MGR_ARB_STATS_EN defined: 70000 handshakes by requester 0 -> grant_cnt_o[0]=16'hFFFF and grant_cnt_o[1]=0.
